// File: rtl/cms_axis_downsizer.sv
// Wide-to-narrow AXI-Stream serialiser for continuous_monitoring_system trace packets.
// Each accepted wide beat is emitted LSB slice first; tlast rides on the final slice.
module cms_axis_downsizer #(
  parameter int IN_WIDTH  = 1024,
  parameter int OUT_WIDTH = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                 S_AXIS_tlast,
  output logic                 M_AXIS_tvalid,
  input  logic                 M_AXIS_tready,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                 M_AXIS_tlast,
  output logic [CNT_WIDTH-1:0] beats_in_count,
  output logic [CNT_WIDTH-1:0] packets_out_count
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
    $error("cms_axis_downsizer: IN_WIDTH must be an integer multiple >= 2 of OUT_WIDTH");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                             state_p0;
  logic [RATIO-1:0][OUT_WIDTH-1:0]    data_p0;
  logic                               last_p0;
  logic [IDX_W-1:0]                   idx_p0;
  logic [CNT_WIDTH-1:0]               beat_cnt_p0;
  logic [CNT_WIDTH-1:0]               pkt_cnt_p0;

  logic on_last;
  logic s_hs;
  logic m_hs;

  assign on_last = (idx_p0 == LAST_IDX);

  // Outputs are decoded from registers only; tdata is forced to zero while empty.
  assign M_AXIS_tvalid = (state_p0 == DRAIN);
  assign M_AXIS_tdata  = M_AXIS_tvalid ? data_p0[idx_p0] : '0;
  assign M_AXIS_tlast  = M_AXIS_tvalid & last_p0 & on_last;

  // A new wide beat may enter while the final slice of the current one leaves.
  assign S_AXIS_tready = (state_p0 == EMPTY) | (M_AXIS_tready & on_last);

  assign s_hs = S_AXIS_tvalid & S_AXIS_tready;
  assign m_hs = M_AXIS_tvalid & M_AXIS_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= EMPTY;
      idx_p0   <= '0;
      last_p0  <= 1'b0;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (s_hs) begin
            state_p0 <= DRAIN;
            idx_p0   <= '0;
            last_p0  <= S_AXIS_tlast;
          end
        end
        DRAIN: begin
          if (m_hs) begin
            if (on_last) begin
              idx_p0 <= '0;
              if (s_hs) begin
                last_p0 <= S_AXIS_tlast;
              end else begin
                state_p0 <= EMPTY;
                last_p0  <= 1'b0;
              end
            end else begin
              idx_p0 <= idx_p0 + IDX_W'(1);
            end
          end
        end
        default: begin
          state_p0 <= EMPTY;
          idx_p0   <= '0;
          last_p0  <= 1'b0;
        end
      endcase
    end
  end

  // Payload register carries no reset; its contents are masked until loaded.
  always_ff @(posedge clk) begin
    if (s_hs) begin
      data_p0 <= S_AXIS_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_p0 <= '0;
      pkt_cnt_p0  <= '0;
    end else begin
      if (s_hs) begin
        beat_cnt_p0 <= beat_cnt_p0 + CNT_WIDTH'(1);
      end
      if (m_hs && M_AXIS_tlast) begin
        pkt_cnt_p0 <= pkt_cnt_p0 + CNT_WIDTH'(1);
      end
    end
  end

  assign beats_in_count    = beat_cnt_p0;
  assign packets_out_count = pkt_cnt_p0;

endmodule
